// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit.
// Opcode values, ALUOp codes (identical to the ALU decoder's encoding),
// datapath select codes and the main-control state encoding.
package mips_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // ALUOp towards the ALU decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SrcBReg    = 2'b00;
  localparam logic [1:0] SrcBFour   = 2'b01;
  localparam logic [1:0] SrcBImm    = 2'b10;
  localparam logic [1:0] SrcBImmSh2 = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // State codes are visible on state_o, so the values are fixed.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11,
    StReset    = 4'd15
  } ctrl_state_e;

endpackage

// File: rtl/mips_multicycle_main_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback per opcode, drives datapath
// enables, mux selects and ALUOp (consumed by the ALU decoder together with funct).
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   opcode_i            instr[31:26], decoded in DECODE and latched there
//   zero_i              ALU zero flag, only used in BRANCH
//   mem_ready_i         memory completes the access this cycle
//   alu_op_o            00 add, 01 sub, 10 use funct
//   alu_src_a_o/_b_o    ALU operand selects
//   pc_src_o, pc_en_o   PC source select and PC load enable
//   iord_o              memory address select (0 PC, 1 ALUOut)
//   ir_write_o, mem_write_o, reg_write_o   write strobes
//   reg_dst_o, mem_to_reg_o               register file write selects
//   illegal_op_o        one-cycle pulse on an unknown opcode in DECODE
//   state_o             current state code (debug)
module mips_multicycle_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [1:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       pc_en_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  ctrl_state_e state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic        pc_write, branch;

  // Latched opcode keeps MEMADR's lw/sw choice stable even if opcode_i moves.
  assign opcode_d = (state_q == StDecode) ? opcode_i : opcode_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StReset;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d      = StFetch;
    alu_op_o     = AluOpAdd;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SrcBReg;
    pc_src_o     = PcSrcAlu;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    illegal_op_o = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;

    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        alu_src_b_o = SrcBFour;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
        state_d     = mem_ready_i ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b_o = SrcBImmSh2;
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi: begin
            if (SUPPORT_ADDI) state_d = StAddiExec;
            else illegal_op_o = 1'b1;
          end
          OpJ: begin
            if (SUPPORT_JUMP) state_d = StJump;
            else illegal_op_o = 1'b1;
          end
          default:    illegal_op_o = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        state_d     = (opcode_q == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        iord_o  = 1'b1;
        state_d = mem_ready_i ? StMemWb : StMemRead;
      end
      StMemWb: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      StMemWrite: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
        state_d     = mem_ready_i ? StFetch : StMemWrite;
      end
      StExecute: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluOpFunct;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluOpSub;
        pc_src_o    = PcSrcAluOut;
        branch      = 1'b1;
      end
      StAddiExec: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        state_d     = StAddiWb;
      end
      StAddiWb: reg_write_o = 1'b1;
      StJump: begin
        pc_src_o = PcSrcJump;
        pc_write = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign pc_en_o = pc_write | (branch & zero_i);
  assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_main_ctrl.sv
module tb_mips_multicycle_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // Two instances sharing inputs: full feature set, and one without addi/j.
  logic [1:0] a_aop, a_sb, a_ps, b_aop, b_sb, b_ps;
  logic       a_sa, a_io, a_ir, a_mw, a_rw, a_rd, a_m2r, a_pe, a_il;
  logic       b_sa, b_io, b_ir, b_mw, b_rw, b_rd, b_m2r, b_pe, b_il;
  logic [3:0] a_st, b_st;

  mips_multicycle_main_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .alu_op_o(a_aop), .alu_src_a_o(a_sa), .alu_src_b_o(a_sb), .pc_src_o(a_ps), .iord_o(a_io),
    .ir_write_o(a_ir), .mem_write_o(a_mw), .reg_write_o(a_rw), .reg_dst_o(a_rd),
    .mem_to_reg_o(a_m2r), .pc_en_o(a_pe), .illegal_op_o(a_il), .state_o(a_st)
  );

  mips_multicycle_main_ctrl #(.SUPPORT_ADDI(1'b0), .SUPPORT_JUMP(1'b0)) dut_nj (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .alu_op_o(b_aop), .alu_src_a_o(b_sa), .alu_src_b_o(b_sb), .pc_src_o(b_ps), .iord_o(b_io),
    .ir_write_o(b_ir), .mem_write_o(b_mw), .reg_write_o(b_rw), .reg_dst_o(b_rd),
    .mem_to_reg_o(b_m2r), .pc_en_o(b_pe), .illegal_op_o(b_il), .state_o(b_st)
  );

  always #5 clk = ~clk;

  logic [18:0] obs_a, obs_b;
  assign obs_a = {a_st, a_aop, a_sa, a_sb, a_ps, a_io, a_ir, a_mw, a_rw, a_rd, a_m2r, a_pe, a_il};
  assign obs_b = {b_st, b_aop, b_sa, b_sb, b_ps, b_io, b_ir, b_mw, b_rw, b_rd, b_m2r, b_pe, b_il};

  int errors = 0;
  int checks = 0;
  bit sel_nj = 1'b0;  // which instance the reference plan is checked against

  typedef struct packed {
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [18:0] exp;
  } cyc_t;

  cyc_t plan[$];

  // Expected output vector: {state, alu_op, src_a, src_b, pc_src, iord, ir_write,
  // mem_write, reg_write, reg_dst, mem_to_reg, pc_en, illegal_op}.
  function automatic logic [18:0] ev(input logic [3:0] st, input logic [1:0] aop,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic io, input logic ir,
                                     input logic mw, input logic rw, input logic rd,
                                     input logic m2r, input logic pe, input logic il);
    return {st, aop, sa, sb, ps, io, ir, mw, rw, rd, m2r, pe, il};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(63));
  endfunction

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [18:0] e);
    cyc_t c;
    c.mr = mr; c.z = z; c.op = op; c.exp = e;
    plan.push_back(c);
  endtask

  // Reference model: one instruction as a list of cycles. The opcode input only
  // matters in decode, so every other cycle drives a random opcode.
  task automatic model_instr(input logic [5:0] op, input int fstall, input int mstall,
                             input logic bz);
    bit has_addi = !sel_nj;
    bit has_j    = !sel_nj;
    bit lw = (op == 6'h23), sw = (op == 6'h2B), rt = (op == 6'h00), beq = (op == 6'h04);
    bit addi = (op == 6'h08) && has_addi;
    bit jmp  = (op == 6'h02) && has_j;
    bit legal = lw || sw || rt || beq || addi || jmp;
    // fetch: PC+4, IR load and PC load only on the accepted cycle
    for (int i = 0; i < fstall; i++)
      push(1'b0, rnd1(), rnd_op(), ev(0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, rnd1(), rnd_op(), ev(0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    // decode: branch target precompute, illegal pulse if not executable
    push(rnd1(), rnd1(), op, ev(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, !legal));
    if (lw || sw)
      push(rnd1(), rnd1(), rnd_op(), ev(2, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (lw) begin
      for (int i = 0; i < mstall; i++)
        push(1'b0, rnd1(), rnd_op(), ev(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      push(1'b1, rnd1(), rnd_op(), ev(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      push(rnd1(), rnd1(), rnd_op(), ev(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    end
    if (sw) begin
      for (int i = 0; i < mstall; i++)
        push(1'b0, rnd1(), rnd_op(), ev(5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      push(1'b1, rnd1(), rnd_op(), ev(5, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    end
    if (rt) begin
      push(rnd1(), rnd1(), rnd_op(), ev(6, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(rnd1(), rnd1(), rnd_op(), ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    end
    if (beq)
      push(rnd1(), bz, rnd_op(), ev(8, 2'b01, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, bz, 0));
    if (addi) begin
      push(rnd1(), rnd1(), rnd_op(), ev(9, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(rnd1(), rnd1(), rnd_op(), ev(10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    end
    if (jmp)
      push(rnd1(), rnd1(), rnd_op(), ev(11, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0));
  endtask

  // Entered and left at posedge+1; drives each planned cycle and checks it.
  task automatic run_plan(input string name);
    int n = 0;
    logic [18:0] obs;
    while (plan.size() > 0) begin
      cyc_t c = plan.pop_front();
      mem_ready = c.mr; zero = c.z; opcode = c.op;
      #1;
      obs = sel_nj ? obs_b : obs_a;
      checks++;
      if (obs !== c.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h, expected %h (state got %0d want %0d)",
                 name, n, obs, c.exp, obs[18:15], c.exp[18:15]);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [18:0] rst_v = ev(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23;
    #1;
    checks += 2;
    if (obs_a !== rst_v) begin errors++; $display("FAIL reset_hold: got %h want %h", obs_a, rst_v); end
    if (obs_b !== rst_v) begin errors++; $display("FAIL reset_hold_nj: got %h want %h", obs_b, rst_v); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_a !== rst_v) begin errors++; $display("FAIL reset_release: got %h want %h", obs_a, rst_v); end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1;
    checks += 2;
    if (a_st !== 4'd0) begin errors++; $display("FAIL reset_to_fetch: got %0d want 0", a_st); end
    if (b_st !== 4'd0) begin errors++; $display("FAIL reset_to_fetch_nj: got %0d want 0", b_st); end
    @(posedge clk); #1;  // consumed one stalled fetch cycle
  endtask

  task automatic test_lw_stall();
    model_instr(6'h23, 2, 2, 1'b0);
    checks++;
    if (plan.size() != 9) begin
      errors++; $display("FAIL lw_stall_length: got %0d want 9", plan.size());
    end
    run_plan("lw_stall");
  endtask

  task automatic test_rtype();
    model_instr(6'h00, 0, 0, 1'b0);
    run_plan("rtype");
  endtask

  task automatic test_branch();
    model_instr(6'h04, 0, 0, 1'b1);
    model_instr(6'h04, 1, 0, 1'b0);
    run_plan("beq");
  endtask

  task automatic test_illegal();
    model_instr(6'h3F, 0, 0, 1'b0);
    model_instr(6'h00, 0, 0, 1'b0);  // returns to a clean fetch
    run_plan("illegal");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op = (i % 5 == 4) ? rnd_op() : ops[$urandom_range(7)];
      model_instr(op, $urandom_range(3), $urandom_range(3), rnd1());
    end
    run_plan("back_to_back");
  endtask

  task automatic test_no_jump_abort();
    sel_nj = 1'b1;
    test_reset();
    model_instr(6'h02, 0, 0, 1'b0);
    model_instr(6'h08, 0, 0, 1'b0);
    model_instr(6'h23, 1, 1, 1'b0);
    for (int i = 0; i < 10; i++)
      model_instr(rnd_op(), $urandom_range(2), $urandom_range(2), rnd1());
    // sw stalled in MEMWRITE, then reset mid-stall
    model_instr(6'h2B, 0, 3, 1'b0);
    void'(plan.pop_back());  // drop the accepting cycle; reset replaces it
    run_plan("no_jump");
    mem_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    checks += 2;
    if (b_mw !== 1'b0) begin errors++; $display("FAIL abort_mem_write: got %b want 0", b_mw); end
    if (b_st !== 4'd15) begin errors++; $display("FAIL abort_state: got %0d want 15", b_st); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_instr(6'h00, 0, 0, 1'b0);
    run_plan("after_abort");
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_rtype();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_no_jump_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
